// File: rtl/nios2core_keypio.sv
// nios2core_keypio
// ----------------
// Avalon-MM s1 slave PIO for push-keys and LEDs on the Nios II data master.
// Key inputs are synchronised, debounced on a prescaled sample tick, and their
// rising edges are latched into a write-1-to-clear capture register that can
// raise a maskable level interrupt. A plain output register drives the LEDs.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   reset_n    synchronous active-low reset
//   address    Avalon word address (0 keys, 1 irq mask, 2 LED readback, 3 edges)
//   chipselect Avalon slave select
//   write_n    Avalon write strobe, active-low
//   writedata  Avalon write data (only [WIDTH-1:0] used)
//   readdata   Avalon read data, registered, loaded every cycle from address
//   in_port    asynchronous key inputs
//   out_port   LED output register
//   irq        level interrupt, active-high
module nios2core_keypio #(
  parameter int unsigned      WIDTH           = 3,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_OUT       = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  typedef enum logic [1:0] {
    ADDR_KEYS  = 2'd0,
    ADDR_MASK  = 2'd1,
    ADDR_LEDS  = 2'd2,
    ADDR_EDGES = 2'd3
  } addr_e;

  // A one-cycle period still needs a 1-bit counter that simply stays at 0.
  localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] presc_cnt;
  logic             tick;

  logic [WIDTH-1:0] sync_s1, sync_s2;
  logic [WIDTH-1:0] smp, deb, deb_q;
  logic [WIDTH-1:0] agree, rise;
  logic [WIDTH-1:0] edgecapture, irq_mask;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rd_sel;
  logic             wr_en;

  // Upper write-data bits are architecturally ignored.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en = chipselect && !write_n;
  assign tick  = (presc_cnt == CNT_LAST);
  assign rise  = deb & ~deb_q;
  // A bit is accepted only when this tick's sample matches the previous one.
  assign agree = ~(sync_s2 ^ smp);

  // NOTE: every variable written here gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_sel = '0;
    clr    = '0;
    if (wr_en && addr_e'(address) == ADDR_EDGES) begin
      clr = writedata[WIDTH-1:0];
    end
    unique case (addr_e'(address))
      ADDR_KEYS:  rd_sel = deb;
      ADDR_MASK:  rd_sel = irq_mask;
      ADDR_LEDS:  rd_sel = out_port;
      ADDR_EDGES: rd_sel = edgecapture;
      default:    rd_sel = '0;
    endcase
  end

  // NOTE: reset is sampled on the clock edge (synchronous), so it sits inside
  // the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata    <= '0;
      out_port    <= RESET_OUT;
      irq_mask    <= '0;
      edgecapture <= '0;
      irq         <= 1'b0;
      sync_s1     <= '0;
      sync_s2     <= '0;
      smp         <= '0;
      deb         <= '0;
      deb_q       <= '0;
      presc_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register below see the
      // pre-edge value of the others, which is what the pipeline relies on.
      sync_s1 <= in_port;
      sync_s2 <= sync_s1;

      // Free-running; bus traffic never restarts it.
      presc_cnt <= tick ? '0 : presc_cnt + CNT_W'(1);

      if (tick) begin
        smp <= sync_s2;
        deb <= (deb & ~agree) | (sync_s2 & agree);
      end
      deb_q <= deb;

      // Set after clear, so a rise coinciding with a clear survives.
      edgecapture <= (edgecapture & ~clr) | rise;
      irq         <= |(edgecapture & irq_mask);

      if (wr_en && addr_e'(address) == ADDR_KEYS) out_port <= writedata[WIDTH-1:0];
      if (wr_en && addr_e'(address) == ADDR_MASK) irq_mask <= writedata[WIDTH-1:0];

      readdata <= 32'(rd_sel);
    end
  end

endmodule

// File: tb/tb_nios2core_keypio.sv
// Self-checking bench for nios2core_keypio. Two instances share one bus and key
// inputs: dut_a samples every cycle, dut_b every 4th cycle. A behavioural model
// predicts readdata/out_port/irq for both on every cycle; directed steps add
// fixed expectations for the key scenarios, followed by a random phase.
module tb_nios2core_keypio;

  localparam int W = 3;
  localparam logic [W-1:0] RST_OUT = 3'b101;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_a, rd_b;
  logic [W-1:0]  out_a, out_b;
  logic          irq_a, irq_b;

  always #5 clk = ~clk;

  nios2core_keypio #(.WIDTH(W), .DEBOUNCE_CYCLES(1), .RESET_OUT(RST_OUT)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_port), .out_port(out_a), .irq(irq_a)
  );

  nios2core_keypio #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .RESET_OUT(RST_OUT)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b),
    .in_port(in_port), .out_port(out_b), .irq(irq_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int unsigned  period [2] = '{1, 4};
  int unsigned  m_age  [2];          // cycles since reset release
  logic [W-1:0] m_near [2];          // key value one edge old
  logic [W-1:0] m_far  [2];          // key value two edges old (usable value)
  logic [W-1:0] m_last_sample [2];   // value taken at the previous sample tick
  logic [W-1:0] m_keys [2];          // accepted key state
  logic [W-1:0] m_keys_prev [2];
  logic [W-1:0] m_edges [2];
  logic [W-1:0] m_mask [2];
  logic [W-1:0] m_leds [2];
  logic [31:0]  m_rd [2];
  logic         m_irq [2];

  task automatic model_edge(input int k);
    logic [W-1:0] rises, clears;
    logic         wr, sample_now;
    if (!reset_n) begin
      m_age[k] = 0; m_near[k] = '0; m_far[k] = '0; m_last_sample[k] = '0;
      m_keys[k] = '0; m_keys_prev[k] = '0; m_edges[k] = '0; m_mask[k] = '0;
      m_leds[k] = RST_OUT; m_rd[k] = '0; m_irq[k] = 1'b0;
    end else begin
      wr         = chipselect && !write_n;
      sample_now = (m_age[k] % period[k]) == period[k] - 1;
      m_age[k]++;
      rises  = m_keys[k] & ~m_keys_prev[k];
      clears = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
      case (address)
        2'd0: m_rd[k] = 32'(m_keys[k]);
        2'd1: m_rd[k] = 32'(m_mask[k]);
        2'd2: m_rd[k] = 32'(m_leds[k]);
        default: m_rd[k] = 32'(m_edges[k]);
      endcase
      m_irq[k]   = |(m_edges[k] & m_mask[k]);
      m_edges[k] = (m_edges[k] & ~clears) | rises;
      if (wr && address == 2'd0) m_leds[k] = writedata[W-1:0];
      if (wr && address == 2'd1) m_mask[k] = writedata[W-1:0];
      m_keys_prev[k] = m_keys[k];
      if (sample_now) begin
        for (int i = 0; i < W; i++)
          if (m_far[k][i] == m_last_sample[k][i]) m_keys[k][i] = m_far[k][i];
        m_last_sample[k] = m_far[k];
      end
      m_far[k]  = m_near[k];
      m_near[k] = in_port;
    end
  endtask

  always @(posedge clk) begin
    model_edge(0);
    model_edge(1);
  end

  task automatic compare_all();
    check("a.readdata", rd_a, m_rd[0]);
    check("a.out_port", 32'(out_a), 32'(m_leds[0]));
    check("a.irq", 32'(irq_a), 32'(m_irq[0]));
    check("b.readdata", rd_b, m_rd[1]);
    check("b.out_port", 32'(out_b), 32'(m_leds[1]));
    check("b.irq", 32'(irq_b), 32'(m_irq[1]));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    step(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;

    // Reset values
    step(2);
    check("rst.out_port", 32'(out_a), 32'h5);
    check("rst.readdata", rd_a, 32'h0);
    check("rst.irq", 32'(irq_a), 32'h0);
    reset_n = 1'b1; address = 2'd3;
    step(1);
    check("rst.edgecapture", rd_a, 32'h0);

    // Output path with upper write bits ignored
    bus_write(2'd0, 32'hFFFF_FFFF);
    check("wr.out_port", 32'(out_a), 32'h7);
    address = 2'd2;
    step(1);
    check("rd.out_port", rd_a, 32'h7);

    // Debounce latency with a tick every cycle
    address = 2'd0; in_port = 3'b010;
    step(4);
    check("deb.before", rd_a, 32'h0);
    step(1);
    check("deb.latency", rd_a, 32'h2);
    address = 2'd3;
    step(1);
    check("deb.edgecapture", rd_a, 32'h2);

    // Single-cycle glitch rejected
    step(20);
    bus_write(2'd3, 32'h7);
    step(2);
    in_port = 3'b000;
    step(1);
    in_port = 3'b010;
    step(20);
    address = 2'd0;
    step(1);
    check("glitch.deb_a", rd_a, 32'h2);
    check("glitch.deb_b", rd_b, 32'h2);
    address = 2'd3;
    step(1);
    check("glitch.edge_a", rd_a, 32'h0);
    check("glitch.edge_b", rd_b, 32'h0);

    // Interrupt set, clear by write-1, clear by masking
    bus_write(2'd1, 32'h2);
    in_port = 3'b000; step(20);
    in_port = 3'b010; step(20);
    check("irq.set_a", 32'(irq_a), 32'h1);
    check("irq.set_b", 32'(irq_b), 32'h1);
    bus_write(2'd3, 32'h2);
    check("irq.clr_hold", 32'(irq_a), 32'h1);
    step(1);
    check("irq.clr_a", 32'(irq_a), 32'h0);
    check("irq.clr_b", 32'(irq_b), 32'h0);
    in_port = 3'b000; step(20);
    in_port = 3'b010; step(20);
    check("irq.reset_a", 32'(irq_a), 32'h1);
    bus_write(2'd1, 32'h0);
    step(1);
    check("irq.masked_a", 32'(irq_a), 32'h0);
    check("irq.masked_b", 32'(irq_b), 32'h0);

    // Set beats clear on the same bit in the same cycle
    in_port = 3'b011;
    step(4);
    bus_write(2'd3, 32'h1);
    address = 2'd3;
    step(1);
    check("collide.edge_a", rd_a, 32'h3);

    // Reset mid-operation with keys held high
    in_port = 3'b111;
    step(3);
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1; address = 2'd3;
    step(5);
    check("rstmid.edge_early", rd_a, 32'h0);
    step(1);
    check("rstmid.edge_a", rd_a, 32'h7);
    check("rstmid.irq_a", 32'(irq_a), 32'h0);

    // Random traffic against the model
    repeat (400) begin
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      if ($urandom_range(0, 11) == 0) in_port = W'($urandom);
      reset_n    = ($urandom_range(0, 199) != 0);
      step(1);
    end
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nios2core_keypio.md
Name: nios2core_keypio

Overview:
Parameterised Avalon-MM slave PIO for push-keys and LEDs. It is the successor to the fixed 3-bit key PIO and adds a width parameter, input synchronisation, a tick-based debouncer, rising-edge capture and a maskable interrupt. It sits on the Nios II data master as an s1 slave: in_port comes from the board keys and out_port drives the LEDs.

Parameters:
WIDTH, 3, number of input bits and number of output bits (1..32)
DEBOUNCE_CYCLES, 50000, clock cycles between debounce sample ticks (>=1; 1 = tick every cycle)
RESET_OUT, 0, value loaded into out_port at reset (WIDTH bits)

Ports:
clk  in  1  system clock; all logic on its rising edge
reset_n  in  1  reset, synchronous, active-low
address  in  2  Avalon word address
chipselect  in  1  Avalon slave select
write_n  in  1  Avalon write strobe, active-low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered
in_port  in  WIDTH  asynchronous key inputs
out_port  out  WIDTH  output register
irq  out  1  level interrupt, active-high

Behaviour:
- Reset: on any clk edge with reset_n=0, these registers clear: readdata=0, out_port=RESET_OUT, irq_mask=0, edgecapture=0, irq=0, sync s1/s2=0, sample smp=0, debounced deb=0, deb_q=0, and the prescaler=0.
- Write: occurs when chipselect=1 and write_n=0. Only writedata[WIDTH-1:0] is used.
- Address 0: write loads out_port.
- Address 1: write loads irq_mask.
- Address 2: write is ignored.
- Address 3: write-1-to-clear of edgecapture.
- Read: every cycle, readdata is loaded from the current address, independent of chipselect. Read latency is 1 cycle. Bits [31:WIDTH] are always 0.
- Read map: 0 = deb, 1 = irq_mask, 2 = out_port readback, 3 = edgecapture.
- Synchroniser: s1<=in_port, s2<=s1 every cycle.
- Prescaler: counts 0..DEBOUNCE_CYCLES-1 and wraps to 0. tick=1 on the cycle the count equals DEBOUNCE_CYCLES-1.
- Debounce: on a tick, smp<=s2. For each bit, if s2==smp, deb<=s2. A change is accepted only after two consecutive ticks agree; single-tick glitches are rejected.
- With DEBOUNCE_CYCLES=1 and in_port stable after a change before edge 0: s1 at edge 1, s2 at edge 2, smp at edge 3, deb at edge 4, edgecapture at edge 5, irq at edge 6, readdata address 0 at edge 5.
- Edge detect: every cycle deb_q<=deb. rise = deb & ~deb_q. edgecapture <= (edgecapture & ~clr) | rise, where clr is the address-3 write mask. If set and clear hit the same bit in the same cycle, set wins.
- irq: registered, irq <= |(edgecapture & irq_mask). It deasserts 1 cycle after the last contributing bit is cleared or masked.
- Falling edges of deb are not captured.
- Reset mid-debounce: all progress is discarded. Because deb resets to 0, a key held high through reset is re-detected as a rising edge. irq_mask=0 after reset, so no irq fires until software unmasks.
- The prescaler free-runs and is not restarted by bus accesses.

Test Plan:
1. Reset: reset_n=0 for 2 clocks with RESET_OUT=5 -> out_port=3'b101; readdata=0, irq=0, edgecapture=0.
2. Output path: write address 0 data 0xFFFFFFFF (WIDTH=3) -> out_port=3'b111 next cycle; read address 2 -> readdata=0x00000007 one cycle after address is presented.
3. Debounce latency: DEBOUNCE_CYCLES=1, in_port 000->010 -> address 0 readdata=0x2 exactly 5 edges later; edgecapture=0x2 at edge 5. Then a 1-cycle 010->000->010 glitch with DEBOUNCE_CYCLES=4 -> deb stays 010, no new capture.
4. Interrupt: mask=0x2, bit1 rises -> irq=1. Write 0x2 to address 3 -> irq=0 two cycles after the write. Write mask=0 while captured -> irq=0 next cycle+1.
5. Collision: rise on bit0 in the same cycle as a write-1-to-clear of bit0 at address 3 -> edgecapture bit0 remains 1.
6. Reset mid-operation: assert reset_n=0 while in_port=111 is held, then release -> edgecapture=0x7 after 5 edges (tick=1), irq stays 0 because mask=0.
